fir_tap_feeder: RTL and testbench

- Front end of the 20-tap voice FIR. Accepts one 16-bit audio sample per in_valid and keeps a 20-deep sliding sample window.
- Holds a double-buffered coefficient bank and presents both as flattened a/b vectors to the downstream multiply-sum stage (fixed 6-cycle pipeline, ce-gated).
- Generates that stage's ce, plus a sum_valid strobe aligned to the cycle its 37-bit result is valid.

---
 rtl/fir_tap_feeder_if.sv | 43 ++++
 rtl/fir_tap_feeder.sv | 150 +++++++++++++++
 tb/tb_fir_tap_feeder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_tap_feeder_if
//  Purpose  : Bundles the sample, coefficient-load and tap-output signals of
//             the 20-tap voice FIR front end.
//  Ports    : master - producer side (drives samples/coefs, sees taps)
//             slave  - fir_tap_feeder side
//  Revision : 1.0  initial release
// ============================================================================
interface fir_tap_feeder_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_TAPS = 20
);
  // sample stream and control
  logic                      in_valid;
  logic [WIDTH-1:0]          in_sample;
  logic                      flush;
  // coefficient loading
  logic                      coef_we;
  logic [4:0]                coef_addr;
  logic [WIDTH-1:0]          coef_data;
  logic                      coef_swap;
  // outputs to the multiply-sum stage and status
  logic [WIDTH*NUM_TAPS-1:0] taps_a;
  logic [WIDTH*NUM_TAPS-1:0] taps_b;
  logic                      sum_ce;
  logic                      sum_valid;
  logic                      primed;
  logic                      swap_pending;

  modport master (
    output in_valid, in_sample, flush,
    output coef_we, coef_addr, coef_data, coef_swap,
    input  taps_a, taps_b, sum_ce, sum_valid, primed, swap_pending
  );

  modport slave (
    input  in_valid, in_sample, flush,
    input  coef_we, coef_addr, coef_data, coef_swap,
    output taps_a, taps_b, sum_ce, sum_valid, primed, swap_pending
  );
endinterface
`default_nettype wire

// File: rtl/fir_tap_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : fir_tap_feeder
//  Purpose  : Front end of the voice FIR. Keeps a NUM_TAPS-deep sliding
//             sample window and a double-buffered coefficient bank, and
//             presents both as flattened vectors to a free-running
//             LATENCY-cycle multiply-sum stage. Generates that stage's clock
//             enable and a sum_valid strobe aligned with its result.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             bus (slave)       - in_valid/in_sample/flush sample stream,
//                                 coef_we/coef_addr/coef_data/coef_swap bank
//                                 loading, taps_a/taps_b vectors, sum_ce,
//                                 sum_valid, primed, swap_pending
//  Revision : 1.0  initial release
// ============================================================================
module fir_tap_feeder #(
  parameter int WIDTH    = 16,
  parameter int NUM_TAPS = 20,  // must be even
  parameter int LATENCY  = 6
) (
  input  logic              clk,
  input  logic              rst,
  fir_tap_feeder_if.slave   bus
);

  localparam int               c_CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(NUM_TAPS);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]          taps_q  [NUM_TAPS];
  logic [WIDTH-1:0]          taps_d  [NUM_TAPS];
  logic [WIDTH-1:0]          bank0_q [NUM_TAPS];
  logic [WIDTH-1:0]          bank0_d [NUM_TAPS];
  logic [WIDTH-1:0]          bank1_q [NUM_TAPS];
  logic [WIDTH-1:0]          bank1_d [NUM_TAPS];
  logic                      active_q,       active_d;
  logic                      swap_pending_q, swap_pending_d;
  logic [c_CNT_W-1:0]        count_q,        count_d;
  logic [LATENCY:0]          vpipe_q,        vpipe_d;
  logic                      primed_q;
  logic                      sum_ce_q;
  logic [WIDTH*NUM_TAPS-1:0] taps_b_q,       taps_b_d;
  logic [WIDTH*NUM_TAPS-1:0] w_taps_a;

  logic w_accept;
  logic w_do_swap;
  logic w_launch;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // flush wins over a simultaneous sample; the sample is simply dropped
    w_accept  = bus.in_valid & ~bus.flush;
    // the bank exchange is tied to an accepted sample so a window and its
    // coefficients always change on the same edge
    w_do_swap = w_accept & (swap_pending_q | bus.coef_swap);

    // sample window
    taps_d = taps_q;
    if (bus.flush) begin
      for (int k = 0; k < NUM_TAPS; k++) taps_d[k] = '0;
    end else if (w_accept) begin
      taps_d[0] = bus.in_sample;
      for (int k = 1; k < NUM_TAPS; k++) taps_d[k] = taps_q[k-1];
    end

    // fill count saturates at a full window
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (w_accept && (count_q != c_FULL)) begin
      count_d = count_q + c_CNT_W'(1);
    end

    // every accepted sample that leaves the window full starts a result
    w_launch = w_accept & (count_d == c_FULL);
    vpipe_d  = bus.flush ? '0 : {vpipe_q[LATENCY-1:0], w_launch};

    // writes always target the shadow bank as seen before this edge; on a
    // swap edge that is the bank about to become active, so the write lands
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (bus.coef_we && (bus.coef_addr == 5'(k))) begin
        if (active_q) bank0_d[k] = bus.coef_data;
        else          bank1_d[k] = bus.coef_data;
      end
    end

    active_d = w_do_swap ? ~active_q : active_q;

    swap_pending_d = swap_pending_q;
    if (w_do_swap)          swap_pending_d = 1'b0;
    else if (bus.coef_swap) swap_pending_d = 1'b1;

    // taps_b is held in its own register so the output is a plain flop
    for (int k = 0; k < NUM_TAPS; k++) begin
      taps_b_d[k*WIDTH +: WIDTH] = active_d ? bank1_d[k] : bank0_d[k];
    end

    for (int k = 0; k < NUM_TAPS; k++) begin
      w_taps_a[k*WIDTH +: WIDTH] = taps_q[k];
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q         <= '{default: '0};
      bank0_q        <= '{default: '0};
      bank1_q        <= '{default: '0};
      active_q       <= 1'b0;
      swap_pending_q <= 1'b0;
      count_q        <= '0;
      vpipe_q        <= '0;
      primed_q       <= 1'b0;
      sum_ce_q       <= 1'b0;
      taps_b_q       <= '0;
    end else begin
      taps_q         <= taps_d;
      bank0_q        <= bank0_d;
      bank1_q        <= bank1_d;
      active_q       <= active_d;
      swap_pending_q <= swap_pending_d;
      count_q        <= count_d;
      vpipe_q        <= vpipe_d;
      primed_q       <= (count_d == c_FULL);
      // downstream runs free once out of reset
      sum_ce_q       <= 1'b1;
      taps_b_q       <= taps_b_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.taps_a       = w_taps_a;
  assign bus.taps_b       = taps_b_q;
  assign bus.sum_ce       = sum_ce_q;
  assign bus.sum_valid    = vpipe_q[LATENCY];
  assign bus.primed       = primed_q;
  assign bus.swap_pending = swap_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_tap_feeder
//  Purpose  : Self-checking bench for fir_tap_feeder. A queue-based window
//             model, two coefficient arrays and a list of due cycles predict
//             every output; a behavioural dot-product stage fed from the DUT
//             outputs confirms the sum_valid alignment.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_tap_feeder;
  localparam int WIDTH    = 16;
  localparam int NUM_TAPS = 20;
  localparam int LATENCY  = 6;
  localparam int VW       = WIDTH * NUM_TAPS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_tap_feeder_if #(.WIDTH(WIDTH), .NUM_TAPS(NUM_TAPS)) bus ();

  fir_tap_feeder #(.WIDTH(WIDTH), .NUM_TAPS(NUM_TAPS), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] m_win[$];                 // newest sample at index 0
  logic [WIDTH-1:0] m_bank[2][NUM_TAPS];
  int               m_active;
  bit               m_pending;
  bit               m_ce;
  int               due_q[$];                 // cycles where sum_valid is due
  longint           exp_p_q[$];               // expected result per launch
  longint           hist_q[$];                // dot product of DUT outputs per cycle
  int               cyc = 0;

  function automatic longint dot_model();
    longint s = 0;
    for (int k = 0; k < NUM_TAPS; k++)
      s += longint'($signed(m_win[k])) * longint'($signed(m_bank[m_active][k]));
    return s;
  endfunction

  function automatic longint dot_dut();
    longint s = 0;
    logic [WIDTH-1:0] a, b;
    for (int k = 0; k < NUM_TAPS; k++) begin
      a = bus.taps_a[k*WIDTH +: WIDTH];
      b = bus.taps_b[k*WIDTH +: WIDTH];
      s += longint'($signed(a)) * longint'($signed(b));
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] exp_taps_a();
    logic [VW-1:0] v = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      if (k < m_win.size()) v[k*WIDTH +: WIDTH] = m_win[k];
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_taps_b();
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_TAPS; k++) v[k*WIDTH +: WIDTH] = m_bank[m_active][k];
    return v;
  endfunction

  task automatic model_edge();
    cyc++;
    if (rst) begin
      m_win.delete();
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < NUM_TAPS; k++) m_bank[b][k] = '0;
      m_active  = 0;
      m_pending = 0;
      m_ce      = 0;
      due_q.delete();
      exp_p_q.delete();
      return;
    end
    m_ce = 1;
    if (bus.coef_we && (int'(bus.coef_addr) < NUM_TAPS))
      m_bank[1-m_active][bus.coef_addr] = bus.coef_data;
    if (bus.flush) begin
      m_win.delete();
      due_q.delete();
      exp_p_q.delete();
      if (bus.coef_swap) m_pending = 1;
    end else if (bus.in_valid) begin
      if (m_pending || bus.coef_swap) begin
        m_active  = 1 - m_active;
        m_pending = 0;
      end
      m_win.push_front(bus.in_sample);
      if (m_win.size() > NUM_TAPS) void'(m_win.pop_back());
      if (m_win.size() == NUM_TAPS) begin
        due_q.push_back(cyc + LATENCY);
        exp_p_q.push_back(dot_model());
      end
    end else if (bus.coef_swap) begin
      m_pending = 1;
    end
  endtask

  task automatic tick();
    bit     exp_sv;
    longint p_exp;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("taps_a", bus.taps_a, exp_taps_a());
    check_eq("taps_b", bus.taps_b, exp_taps_b());
    check_eq("primed", VW'(bus.primed), VW'(m_win.size() == NUM_TAPS));
    check_eq("swap_pending", VW'(bus.swap_pending), VW'(m_pending));
    check_eq("sum_ce", VW'(bus.sum_ce), VW'(m_ce));
    exp_sv = (due_q.size() > 0) && (due_q[0] == cyc);
    check_eq("sum_valid", VW'(bus.sum_valid), VW'(exp_sv));
    hist_q.push_back(dot_dut());
    if (exp_sv) begin
      void'(due_q.pop_front());
      p_exp = exp_p_q.pop_front();
      if (hist_q.size() > LATENCY)
        check_eq("sum_p", VW'(hist_q[hist_q.size()-1-LATENCY]), VW'(p_exp));
    end
    if (hist_q.size() > 16) void'(hist_q.pop_front());
  endtask

  task automatic drive(input bit iv, input logic [WIDTH-1:0] s, input bit fl, input bit we,
                       input logic [4:0] a, input logic [WIDTH-1:0] d, input bit sw, input bit r);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_sample = s;
    bus.flush     = fl;
    bus.coef_we   = we;
    bus.coef_addr = a;
    bus.coef_data = d;
    bus.coef_swap = sw;
    tick();
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic sample(input logic [WIDTH-1:0] s);
    drive(1, s, 0, 0, '0, '0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    drive(0, '0, 0, 0, '0, '0, 0, 1);
    drive(0, '0, 0, 0, '0, '0, 0, 1);

    // basic window: coefficients k+1, armed swap, then samples 1..20 and 21
    for (int k = 0; k < NUM_TAPS; k++) drive(0, '0, 0, 1, 5'(k), 16'(k + 1), 0, 0);
    drive(0, '0, 0, 0, '0, '0, 1, 0);
    for (int s = 1; s <= 21; s++) sample(16'(s));
    repeat (8) idle();

    // pending swap held for 10 idle cycles, executed by the next sample
    for (int k = 0; k < NUM_TAPS; k++) drive(0, '0, 0, 1, 5'(k), 16'd1, 0, 0);
    repeat (10) drive(0, '0, 0, 0, '0, '0, 1, 0);
    sample(16'd22);

    // flush three cycles after a launch, then a fresh window
    sample(16'd23);
    idle();
    idle();
    drive(1, 16'd99, 1, 0, '0, '0, 0, 0);
    for (int s = 0; s < NUM_TAPS; s++) sample(16'(100 + s));
    repeat (8) idle();

    // collisions
    drive(1, 16'd55, 1, 0, '0, '0, 0, 0);
    drive(1, 16'd77, 0, 1, 5'd3, 16'h0100, 1, 0);
    drive(0, '0, 0, 1, 5'd25, 16'hBEEF, 0, 0);
    drive(0, '0, 0, 0, '0, '0, 1, 0);
    sample(16'hFFF0);

    // reset while primed and streaming
    for (int s = 0; s < NUM_TAPS + 2; s++) sample(16'($urandom));
    drive(1, 16'h1234, 0, 0, '0, '0, 1, 1);
    idle();
    drive(1, 16'd5, 0, 0, '0, '0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 10) < 7, 16'($urandom), ($urandom % 40) == 0, ($urandom % 5) == 0,
            5'($urandom % 32), 16'($urandom), ($urandom % 16) == 0, ($urandom % 250) == 0);
    end
    repeat (10) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
